// File: rtl/shift_right_unit.sv
// ---------------------------------------------------------------------------
// shift_right_unit
//
// Multi-cycle right shifter for the ALU shift/rotate instructions (srl, sra,
// ror). One bit is shifted per clock. The control unit holds the PC while
// BUSY is high, and the ALU output mux samples RESULT/ZERO on DONE.
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous reset, active low
//   START    in   request; accepted in IDLE or FINISH on a rising edge
//   MODE     in   00 logical, 01 arithmetic, 10 rotate, 11 treated as 00
//   DATA_IN  in   operand, captured when START is accepted
//   SHAMT    in   shift amount, captured when START is accepted
//   RESULT   out  registered final result
//   ZERO     out  registered, high when RESULT is zero
//   BUSY     out  high while an operation is shifting
//   DONE     out  one-cycle pulse; RESULT/ZERO valid from this cycle
// ---------------------------------------------------------------------------
module shift_right_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [7:0]       SHAMT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             accept;

  // Number of single-bit steps for an operation. Rotates wrap modulo the
  // width; the other modes saturate at the width, so an oversized immediate
  // fully drains (or sign-fills) the operand rather than wrapping around.
  function automatic logic [CNT_W-1:0] eff_count(input logic [1:0] mode,
                                                 input logic [7:0] shamt);
    logic [CNT_W-1:0] n;
    if (mode == MODE_ROTATE) begin
      n = CNT_W'(shamt % 8'(WIDTH));
    end else if (shamt > 8'(WIDTH)) begin
      n = CNT_W'(WIDTH);
    end else begin
      n = CNT_W'(shamt);
    end
    return n;
  endfunction

  // One-bit right step; only the bit entering at the MSB depends on the mode.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0]       mode,
                                                  input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_ARITH:  r = {val[WIDTH-1], val[WIDTH-1:1]};
      MODE_ROTATE: r = {val[0],       val[WIDTH-1:1]};
      default:     r = {1'b0,         val[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // A new request is taken from IDLE, or straight out of FINISH so that
  // back-to-back operations lose no cycle. START during SHIFT is ignored.
  assign accept = START && ((state == IDLE) || (state == FINISH));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
      RESULT <= '0;
      ZERO   <= 1'b1;
    end else if (accept) begin
      sreg   <= DATA_IN;
      cnt    <= eff_count(MODE, SHAMT);
      mode_q <= MODE;
      state  <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= shift_step(mode_q, sreg);
            cnt  <= cnt - 1'b1;
          end else begin
            // Only the finished value is ever published to RESULT/ZERO.
            RESULT <= sreg;
            ZERO   <= (sreg == '0);
            state  <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the state register, so BUSY and DONE can never overlap.
  assign BUSY = (state == SHIFT);
  assign DONE = (state == FINISH);

endmodule

// File: tb/tb_shift_right_unit.sv
module tb_shift_right_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [1:0] MODE;
  logic [7:0] DATA_IN;
  logic [7:0] SHAMT;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       BUSY;
  logic       DONE;

  shift_right_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
    .DATA_IN(DATA_IN), .SHAMT(SHAMT), .RESULT(RESULT), .ZERO(ZERO),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] r;
    logic       z;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  logic [7:0] last_r = 8'h00;
  logic       last_z = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the whole operation as plain arithmetic on integers.
  function automatic logic [7:0] ref_model(input logic [1:0] m, input logic [7:0] d,
                                           input logic [7:0] s, output int n);
    int v;
    int r;
    v = int'(d);
    if (m == 2'b10) n = int'(s) % 8;
    else n = (int'(s) > 8) ? 8 : int'(s);
    case (m)
      2'b01: begin
        if (v >= 128) v = v - 256;
        r = (v >>> n) & 255;
      end
      2'b10: r = ((v >> n) | (v << (8 - n))) & 255;
      default: r = v >> n;
    endcase
    return r[7:0];
  endfunction

  // Waits for the unit to be free, presents one request and, when asked,
  // records the expected result and the cycle at which DONE must appear.
  task automatic issue(input logic [1:0] m, input logic [7:0] d,
                       input logic [7:0] s, input bit push);
    int   k;
    int   n;
    exp_t e;
    k = 0;
    @(negedge CLK);
    while (BUSY && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (BUSY) chk("issue_wait_timeout", int'(BUSY), 0);
    MODE = m; DATA_IN = d; SHAMT = s; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    // Post-acceptance input changes must not matter.
    MODE = 2'($urandom); DATA_IN = 8'($urandom); SHAMT = 8'($urandom);
    if (push) begin
      e.r = ref_model(m, d, s, n);
      e.z = (e.r == 8'h00);
      e.t = cyc + n + 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      last_r = 8'h00;
      last_z = 1'b1;
      chk("done_in_reset", int'(DONE), 0);
    end else begin
      chk("busy_done_excl", int'(BUSY & DONE), 0);
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("done_without_request", int'(DONE), 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(RESULT), int'(e.r));
          chk("zero", int'(ZERO), int'(e.z));
          chk("done_cycle", cyc, e.t);
          last_r = e.r;
          last_z = e.z;
        end
      end else begin
        chk("result_hold", int'(RESULT), int'(last_r));
        chk("zero_hold", int'(ZERO), int'(last_z));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] s;
  } dir_t;

  dir_t dir[9] = '{
    '{2'b00, 8'hB4, 8'd3},   '{2'b01, 8'hB4, 8'd3},
    '{2'b10, 8'hB4, 8'd3},   '{2'b11, 8'hB4, 8'd3},
    '{2'b01, 8'h80, 8'd200}, '{2'b00, 8'h80, 8'd200},
    '{2'b10, 8'h80, 8'd8},   '{2'b00, 8'h5A, 8'd0},
    '{2'b00, 8'h01, 8'd1}
  };

  initial begin
    int k;
    RESET = 1'b0; START = 1'b0; MODE = 2'b00; DATA_IN = 8'h00; SHAMT = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_result", int'(RESULT), 0);
    chk("reset_zero", int'(ZERO), 1);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    @(negedge CLK);
    #1 RESET = 1'b1;

    // Directed cases; the last two run back-to-back out of FINISH.
    foreach (dir[i]) issue(dir[i].m, dir[i].d, dir[i].s, 1'b1);

    // START pulsed during SHIFT with a different operand must be ignored.
    issue(2'b00, 8'hC3, 8'd5, 1'b1);
    @(negedge CLK);
    START = 1'b1; DATA_IN = 8'hFF; SHAMT = 8'd0; MODE = 2'b01;
    @(negedge CLK);
    START = 1'b0;

    // Asynchronous reset between edges aborts the operation with no DONE.
    issue(2'b01, 8'h9C, 8'd6, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_result", int'(RESULT), 0);
    chk("abort_zero", int'(ZERO), 1);
    @(negedge CLK);
    #1 RESET = 1'b1;
    issue(2'b01, 8'hB4, 8'd3, 1'b1);

    // Randomised operations, with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] s;
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
      issue(2'($urandom), 8'($urandom), s, 1'b1);
    end

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
Name: shift_right_unit

Overview:
- Multi-cycle 8-bit right-direction shifter for the ALU's shift/rotate instructions (srl, sra, ror). It complements the existing combinational left-shift used for branch offsets.
- Shifts one bit per clock under a START/BUSY/DONE handshake. The control unit stalls the PC while BUSY=1.
- Result and zero flag are registered; the ALU output mux samples them on DONE.

Parameters:
- WIDTH, 8, data width of operand and result
- CNT_W, 4, internal shift counter width; must hold the value WIDTH

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- START  input  1  request; sampled on a rising CLK edge
- MODE  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 reserved (behaves as 00)
- DATA_IN  input  WIDTH  operand; captured on an accepted START
- SHAMT  input  8  shift amount (instruction immediate); captured on an accepted START
- RESULT  output  WIDTH  registered final result
- ZERO  output  1  registered, 1 when RESULT==0
- BUSY  output  1  high while the operation is in progress
- DONE  output  1  single-cycle pulse; RESULT/ZERO valid from this cycle

Behaviour:
- Reset (RESET=0, async): state IDLE, RESULT=0, ZERO=1, BUSY=0, DONE=0, internal shift register and counter cleared. This takes effect immediately, including mid-operation. The aborted operation produces no DONE.
- States: IDLE, SHIFT, FINISH.
- Effective count n:
  - Modes 00/01/11: n = min(SHAMT, 8).
  - Mode 10: n = SHAMT[2:0], i.e. rotate modulo 8.
- IDLE: on an edge with START=1, load the shift register with DATA_IN, load the counter with n, latch MODE, and go to SHIFT. BUSY=1 from that edge.
- SHIFT: BUSY=1, DONE=0.
  - On each edge with counter>0, shift one bit right and decrement the counter.
    - Logical: MSB<=0.
    - Arithmetic: MSB<=old MSB.
    - Rotate: MSB<=old LSB.
  - On an edge with counter==0: RESULT<=shift register, ZERO<=(shift register==0), go to FINISH.
- FINISH: DONE=1, BUSY=0 for exactly one cycle.
  - Next edge: if START=1, accept a new operation as in IDLE (back-to-back); otherwise go to IDLE.
- Latency: START accepted at edge E0 gives DONE high in the cycle after edge E0+n+1. Total n+2 cycles from accept to end of DONE.
- START while in SHIFT is ignored. DATA_IN/SHAMT/MODE changes after acceptance have no effect.
- RESULT and ZERO change only on entry to FINISH (or reset) and hold otherwise. Intermediate shift values are never visible.
- n=8 boundaries:
  - Logical gives 0x00.
  - Arithmetic gives 0x00 or 0xFF depending on the sign bit.
  - SHAMT>8 saturates to 8 for all non-rotate modes; there is no wrap.
- BUSY and DONE are never high together.

Test Plan:
- MODE=00, DATA_IN=0xB4, SHAMT=3 -> RESULT=0x16, ZERO=0, DONE high in the cycle after E0+4, BUSY high for 4 cycles.
- MODE=01, DATA_IN=0xB4, SHAMT=3 -> RESULT=0xF6. MODE=10, same operand -> RESULT=0x96. MODE=11 -> 0x16.
- MODE=01, DATA_IN=0x80, SHAMT=200 -> RESULT=0xFF after 8 shift cycles. MODE=00, same -> RESULT=0x00, ZERO=1. MODE=10, SHAMT=8 -> RESULT=0x80, DONE after E0+1.
- SHAMT=0, MODE=00, DATA_IN=0x5A -> RESULT=0x5A, DONE in the cycle after E0+1. Then START held high in FINISH with DATA_IN=0x01, SHAMT=1 -> second DONE, RESULT=0x00, ZERO=1.
- START pulsed again mid-SHIFT with different DATA_IN -> ignored; first result unchanged, exactly one DONE.
- RESET driven low mid-SHIFT (between edges) -> BUSY=0, RESULT=0, ZERO=1 immediately, no DONE. After release, a new START operates normally.
